// File: rtl/fft_dac_pkg.sv
// Shared encodings and saturation helpers for the FFT-to-DAC formatter.
// The saturation bounds are derived from the DAC width so every user clips identically.
package fft_dac_pkg;

  typedef enum logic [1:0] {
    MODE_RE   = 2'd0,
    MODE_IM   = 2'd1,
    MODE_MAG  = 2'd2,
    MODE_RAMP = 2'd3
  } mode_e;

  localparam int SHIFT_W = 5;

  function automatic longint sat_hi(input int dac_width);
    return (64'sd1 <<< (dac_width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int dac_width);
    return -(64'sd1 <<< (dac_width - 1));
  endfunction

endpackage

// File: rtl/fft_dac_scale_sat.sv
// Arithmetic right shift followed by a clip to the signed DAC range.
// Purely combinational; the clip flag marks any sample that had to be limited.
module fft_dac_scale_sat
  import fft_dac_pkg::*;
#(
  parameter int CW        = 16,
  parameter int DAC_WIDTH = 14
) (
  input  logic [CW+1:0]        val,
  input  logic [SHIFT_W-1:0]   shift,
  output logic [DAC_WIDTH-1:0] dac,
  output logic                 clip
);

  // Compare in a width that holds both the shifted value and the DAC bounds.
  localparam int EW = (CW + 2 > DAC_WIDTH) ? CW + 2 : DAC_WIDTH;
  localparam logic signed [EW-1:0] HI = EW'(sat_hi(DAC_WIDTH));
  localparam logic signed [EW-1:0] LO = EW'(sat_lo(DAC_WIDTH));
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(CW);

  logic [SHIFT_W-1:0]   shift_eff_s;
  logic signed [CW+1:0] shifted_s;
  logic signed [EW-1:0] ext_s;

  // Clamp the shift, scale, then limit to the DAC range.
  always_comb begin
    if (shift > SHIFT_MAX) begin
      shift_eff_s = SHIFT_MAX;
    end else begin
      shift_eff_s = shift;
    end
    shifted_s = $signed(val) >>> shift_eff_s;
    ext_s     = EW'(shifted_s);
    if (ext_s > HI) begin
      dac  = HI[DAC_WIDTH-1:0];
      clip = 1'b1;
    end else if (ext_s < LO) begin
      dac  = LO[DAC_WIDTH-1:0];
      clip = 1'b1;
    end else begin
      dac  = ext_s[DAC_WIDTH-1:0];
      clip = 1'b0;
    end
  end

endmodule

// File: rtl/fft_dac_formatter.sv
// FFT AXI-Stream to dual-lane DAC formatter: source select, scale/saturate,
// frame marker and lane packing behind a two-stage valid/ready pipeline.
module fft_dac_formatter
  import fft_dac_pkg::*;
#(
  parameter int CW           = 16,
  parameter int DAC_WIDTH    = 14,
  parameter int LANE_WIDTH   = 16,
  parameter int LANES        = 2,
  parameter int MARKER_VALUE = (32'sd1 <<< (DAC_WIDTH - 1)) - 32'sd1,
  parameter bit ZERO_IDLE    = 1'b0
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [2*CW-1:0]               s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tuser,
  input  logic                          s_axis_tlast,
  output logic [LANES*LANE_WIDTH-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic [1:0]                    mode,
  input  logic [SHIFT_W-1:0]            shift,
  input  logic                          marker_en,
  output logic [15:0]                   sat_count
);

  localparam int VW = CW + 2;
  localparam logic [DAC_WIDTH-1:0] MARKER_DAC = DAC_WIDTH'(MARKER_VALUE);
  localparam logic [DAC_WIDTH-1:0] RAMP_ONE   = {{(DAC_WIDTH-1){1'b0}}, 1'b1};

  // |x| of a signed component, one bit wider so the most negative value does not wrap.
  function automatic logic [CW:0] abs_ext(input logic [CW-1:0] x);
    logic [CW:0] e;
    e = {x[CW-1], x};
    if (x[CW-1]) begin
      return ~e + {{CW{1'b0}}, 1'b1};
    end else begin
      return e;
    end
  endfunction

  logic [CW-1:0]        re_s;
  logic [CW-1:0]        im_s;
  logic [CW:0]          mag_s;
  logic [DAC_WIDTH-1:0] ramp_now_s;
  logic [VW-1:0]        src_s;
  logic                 in_fire_s;
  logic                 out_fire_s;
  logic                 load_s2_s;

  logic                 v1_r;
  logic [VW-1:0]        s1_val_r;
  logic [SHIFT_W-1:0]   s1_shift_r;
  logic                 s1_marker_r;
  logic                 s1_last_r;
  logic [DAC_WIDTH-1:0] ramp_r;
  logic                 clip_r;

  logic [DAC_WIDTH-1:0]  scaled_s;
  logic                  scaled_clip_s;
  logic [DAC_WIDTH-1:0]  s2_dac_s;
  logic                  s2_clip_s;
  logic [LANE_WIDTH-1:0] lane_s;

  assign re_s  = s_axis_tdata[CW-1:0];
  assign im_s  = s_axis_tdata[2*CW-1:CW];
  assign mag_s = abs_ext(re_s) + abs_ext(im_s);

  // A frame start restarts the ramp so that beat itself carries 0.
  assign ramp_now_s = s_axis_tuser ? {DAC_WIDTH{1'b0}} : ramp_r;

  assign s_axis_tready = aresetn & (~v1_r | ~m_axis_tvalid | m_axis_tready);
  assign in_fire_s     = s_axis_tvalid & s_axis_tready;
  assign load_s2_s     = ~m_axis_tvalid | m_axis_tready;
  assign out_fire_s    = m_axis_tvalid & m_axis_tready;

  // Source select for the incoming beat.
  always_comb begin
    src_s = {VW{1'b0}};
    case (mode_e'(mode))
      MODE_RE:   src_s = {{2{re_s[CW-1]}}, re_s};
      MODE_IM:   src_s = {{2{im_s[CW-1]}}, im_s};
      MODE_MAG:  src_s = {1'b0, mag_s};
      MODE_RAMP: src_s = VW'($signed(ramp_now_s));
      default:   src_s = {VW{1'b0}};
    endcase
  end

  // Stage 1: capture the selected source with its per-beat controls.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      v1_r        <= 1'b0;
      s1_val_r    <= {VW{1'b0}};
      s1_shift_r  <= {SHIFT_W{1'b0}};
      s1_marker_r <= 1'b0;
      s1_last_r   <= 1'b0;
    end else if (s_axis_tready) begin
      v1_r <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        s1_val_r    <= src_s;
        s1_shift_r  <= shift;
        s1_marker_r <= s_axis_tuser & marker_en;
        s1_last_r   <= s_axis_tlast;
      end
    end
  end

  // Ramp advances on every accepted beat and wraps at the DAC range.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ramp_r <= {DAC_WIDTH{1'b0}};
    end else if (in_fire_s) begin
      ramp_r <= ramp_now_s + RAMP_ONE;
    end
  end

  fft_dac_scale_sat #(
    .CW        (CW),
    .DAC_WIDTH (DAC_WIDTH)
  ) u_scale_sat (
    .val   (s1_val_r),
    .shift (s1_shift_r),
    .dac   (scaled_s),
    .clip  (scaled_clip_s)
  );

  // Marker beats bypass the scaled value and never count as clipped.
  always_comb begin
    if (s1_marker_r) begin
      s2_dac_s  = MARKER_DAC;
      s2_clip_s = 1'b0;
    end else begin
      s2_dac_s  = scaled_s;
      s2_clip_s = scaled_clip_s;
    end
  end

  assign lane_s = LANE_WIDTH'($signed(s2_dac_s));

  // Stage 2: output register, held stable while the sink stalls.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= {(LANES*LANE_WIDTH){1'b0}};
      m_axis_tlast  <= 1'b0;
      clip_r        <= 1'b0;
    end else if (load_s2_s) begin
      m_axis_tvalid <= v1_r;
      if (v1_r) begin
        m_axis_tdata <= {LANES{lane_s}};
        m_axis_tlast <= s1_last_r;
        clip_r       <= s2_clip_s;
      end else if (ZERO_IDLE) begin
        m_axis_tdata <= {(LANES*LANE_WIDTH){1'b0}};
      end
    end
  end

  // Count clipped beats as they leave, sticking at all-ones.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sat_count <= 16'h0000;
    end else if (out_fire_s && clip_r && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_fft_dac_formatter.sv
// Self-checking bench: directed pins plus randomized traffic against a scoreboard model.
module tb_fft_dac_formatter;

  localparam int DMAX = 8191;
  localparam int DMIN = -8192;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic [31:0] s_data;
  logic        s_valid, s_ready, s_user, s_last;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last;
  logic [1:0]  mode;
  logic [4:0]  shift;
  logic        marker_en;
  logic [15:0] sat_count;

  // Literal expectations attached to the beat being driven.
  logic        lit_en;
  logic [31:0] lit;
  logic        lit_sat_en;
  logic [15:0] lit_sat;

  fft_dac_formatter dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tuser  (s_user),
    .s_axis_tlast  (s_last),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (m_last),
    .mode          (mode),
    .shift         (shift),
    .marker_en     (marker_en),
    .sat_count     (sat_count)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        clip;
    int          acc;
    logic        lit_en;
    logic [31:0] lit;
    logic        lit_sat_en;
    logic [15:0] lit_sat;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ramp_m = 0;
  int          sat_m = 0;
  logic [31:0] last_out = 32'd0;
  logic        stall_r = 1'b0;
  logic [31:0] stall_data = 32'd0;
  logic        stall_last = 1'b0;
  ent_t        e_m;
  logic [31:0] d_m;
  logic        c_m;
  int          r_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output of one beat computed directly from the arithmetic rules.
  function automatic void model_beat(input logic [1:0] md, input logic [31:0] d, input logic [4:0] sh,
                                     input logic mk, input int rampv,
                                     output logic [31:0] data, output logic clip);
    int re, im, src, v, s;
    re = int'($signed(d[15:0]));
    im = int'($signed(d[31:16]));
    case (md)
      2'd0:    src = re;
      2'd1:    src = im;
      2'd2:    src = (re < 0 ? -re : re) + (im < 0 ? -im : im);
      default: src = rampv;
    endcase
    s = (int'(sh) > 16) ? 16 : int'(sh);
    v = src >>> s;
    clip = 1'b0;
    if (v > DMAX) begin
      v = DMAX; clip = 1'b1;
    end else if (v < DMIN) begin
      v = DMIN; clip = 1'b1;
    end
    if (mk) begin
      v = DMAX; clip = 1'b0;
    end
    data = {v[15:0], v[15:0]};
  endfunction

  // Compare process: every cycle, checked half a clock away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!aresetn) begin
      chk("rst_tvalid", 32'(m_valid), 32'd0);
      chk("rst_tdata", m_data, 32'd0);
      chk("rst_sat_count", 32'(sat_count), 32'd0);
      chk("rst_s_tready", 32'(s_ready), 32'd0);
      q.delete();
      ramp_m = 0; sat_m = 0; last_out = 32'd0; stall_r = 1'b0;
    end else begin
      chk("m_tvalid", 32'(m_valid), 32'((q.size() > 0) && (cyc >= q[0].acc + 2)));
      chk("s_tready", 32'(s_ready), 32'((q.size() < 2) || m_ready));
      chk("sat_count", 32'(sat_count), 32'(sat_m));
      if (stall_r) begin
        chk("stall_tdata", m_data, stall_data);
        chk("stall_tlast", 32'(m_last), 32'(stall_last));
      end
      if (!m_valid) chk("idle_hold", m_data, last_out);
      if (m_valid && m_ready && (q.size() > 0)) begin
        e_m = q.pop_front();
        chk("tdata", m_data, e_m.data);
        chk("tlast", 32'(m_last), 32'(e_m.last));
        if (e_m.lit_en) begin
          chk("lit_tdata", m_data, e_m.lit);
          chk("model_pin", e_m.data, e_m.lit);
        end
        if (e_m.lit_sat_en) chk("lit_sat_count", 32'(sat_count), 32'(e_m.lit_sat));
        if (e_m.clip && sat_m < 65535) sat_m++;
        last_out = e_m.data;
      end
      stall_r    = m_valid & ~m_ready;
      stall_data = m_data;
      stall_last = m_last;
      if (s_valid && s_ready) begin
        r_m = s_user ? 0 : ramp_m;
        model_beat(mode, s_data, shift, s_user & marker_en, r_m, d_m, c_m);
        ramp_m = r_m + 1;
        if (ramp_m > DMAX) ramp_m = DMIN;
        e_m.data = d_m; e_m.last = s_last; e_m.clip = c_m; e_m.acc = cyc;
        e_m.lit_en = lit_en; e_m.lit = lit; e_m.lit_sat_en = lit_sat_en; e_m.lit_sat = lit_sat;
        q.push_back(e_m);
      end
    end
  end

  task automatic send(input logic [1:0] md, input logic [15:0] im, input logic [15:0] re,
                      input logic [4:0] sh, input logic usr, input logic lst, input logic mk,
                      input logic le, input logic [31:0] lv, input logic lse, input logic [15:0] ls);
    int n = 0;
    mode = md; s_data = {im, re}; shift = sh; s_user = usr; s_last = lst; marker_en = mk;
    lit_en = le; lit = lv; lit_sat_en = lse; lit_sat = ls;
    s_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 64);
    if (!s_ready) begin
      $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles", n);
      $fatal(1, "input handshake timeout");
    end
    @(posedge clk); #1;
    s_valid = 1'b0; lit_en = 1'b0; lit_sat_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain_timeout: %0d beats still pending", q.size());
      $fatal(1, "output drain timeout");
    end
  endtask

  function automatic logic [15:0] rand_comp();
    case ($urandom_range(4))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic acc;
    int   b;
    logic [15:0] re;
    aresetn = 1'b1; s_valid = 1'b0; s_data = 32'd0; s_user = 1'b0; s_last = 1'b0;
    m_ready = 1'b1; mode = 2'd0; shift = 5'd0; marker_en = 1'b0;
    lit_en = 1'b0; lit = 32'd0; lit_sat_en = 1'b0; lit_sat = 16'd0;
    #2 aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;

    // Directed beats, each isolated so the two-cycle latency is visible.
    send(2'd0, 16'h0000, 16'h1000, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0400_0400, 1'b1, 16'd0); drain();
    send(2'd0, 16'h0000, 16'h7FFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1FFF_1FFF, 1'b1, 16'd0); drain();
    send(2'd0, 16'h0000, 16'h8000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hE000_E000, 1'b1, 16'd1); drain();
    send(2'd2, 16'd400, -16'sd300, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h02BC_02BC, 1'b1, 16'd2); drain();
    send(2'd1, 16'd400, -16'sd300, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0190_0190, 1'b1, 16'd2); drain();
    send(2'd0, 16'h0000, 16'h8000, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1FFF_1FFF, 1'b1, 16'd2); drain();
    send(2'd0, 16'h0000, 16'h8000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hE000_E000, 1'b1, 16'd2); drain();
    send(2'd0, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 16'd3); drain();
    send(2'd0, 16'h0000, 16'h8000, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 16'd0); drain();
    send(2'd0, 16'h0000, 16'h7FFF, 5'd20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 16'd0); drain();
    send(2'd2, 16'h8000, 16'h8000, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1FFF_1FFF, 1'b0, 16'd0); drain();

    // Eight-beat stream with the sink stalled for cycles 3..7.
    b = 0;
    for (int c = 0; c < 64 && b < 8; c++) begin
      m_ready = (c < 3) || (c > 7);
      re = 16'(b * 100 + 1);
      mode = 2'd0; shift = 5'd0; s_user = 1'b0; marker_en = 1'b0; s_last = (b == 7);
      s_data = {16'h0000, re}; lit_en = 1'b1; lit = {re, re}; lit_sat_en = 1'b0;
      s_valid = 1'b1;
      @(negedge clk);
      if (s_ready) b++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; lit_en = 1'b0; m_ready = 1'b1;
    if (b != 8) begin
      $display("FAIL stall_stream: only %0d of 8 beats accepted", b);
      $fatal(1, "stream timeout");
    end
    drain();

    // Ramp from a frame start, then a reset in the middle of the stream.
    for (int k = 0; k < 5; k++)
      send(2'd3, 16'h0000, 16'h0000, 5'd0, (k == 0), 1'b0, 1'b0, 1'b1, {16'(k), 16'(k)}, 1'b0, 16'd0);
    drain();
    for (int k = 0; k < 3; k++)
      send(2'd3, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0);
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    send(2'd3, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 16'd0);
    drain();

    // Ramp wrap from +max to -min.
    for (int k = 0; k < 8195; k++)
      send(2'd3, 16'h0000, 16'h0000, 5'd0, (k == 0), 1'b0, 1'b0, (k == 8191) || (k == 8192),
           (k == 8191) ? 32'h1FFF_1FFF : 32'hE000_E000, 1'b0, 16'd0);
    drain();

    // Randomized traffic and backpressure; a pending beat is held until accepted.
    acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!s_valid || acc) begin
        s_valid   = ($urandom_range(3) != 0);
        s_data    = {rand_comp(), rand_comp()};
        s_user    = ($urandom_range(7) == 0);
        s_last    = ($urandom_range(7) == 0);
        mode      = 2'($urandom_range(3));
        shift     = 5'($urandom_range(31));
        marker_en = 1'($urandom_range(1));
      end
      m_ready = ($urandom_range(9) < 7);
      @(negedge clk);
      acc = s_valid & s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_dac_formatter.md
# fft_dac_formatter

Parametrised successor to the FFT-to-DAC stream converter. It sits between the FFT core's AXI-Stream output and the dual-channel DAC stream. Per beat it selects a source (real, imaginary, |re|+|im| magnitude or an internal test ramp), applies a runtime right-shift, and saturates to the DAC width. It inserts a frame marker on `tuser`, packs the result into sign-extended DAC lanes, and honours full valid/ready backpressure through a two-stage pipeline.

## Interface
Parameters:
- `CW`, 16: width of each complex component; input word is `{im, re}`.
- `DAC_WIDTH`, 14: signed DAC sample width.
- `LANE_WIDTH`, 16: width of one output lane; `DAC_WIDTH` ≤ `LANE_WIDTH`.
- `LANES`, 2: number of output lanes; lane 0 is the LSBs.
- `MARKER_VALUE`, 2^(`DAC_WIDTH`-1)-1: value forced for a marker beat.
- `ZERO_IDLE`, 0: 1 forces `m_axis_tdata` to 0 whenever `m_axis_tvalid` is 0; 0 holds the last value.

Ports:
- `clk`, in, 1: single clock.
- `aresetn`, in, 1: asynchronous assert, active-low reset.
- `s_axis_tdata`, in, 2*`CW`: `{im[CW-1:0], re[CW-1:0]}`, signed two's complement.
- `s_axis_tvalid` / `s_axis_tready`, in / out, 1: input handshake.
- `s_axis_tuser`, in, 1: first bin of a frame.
- `s_axis_tlast`, in, 1: last bin of a frame.
- `m_axis_tdata`, out, `LANES`*`LANE_WIDTH`: packed DAC lanes.
- `m_axis_tvalid` / `m_axis_tready`, out / in, 1: output handshake.
- `m_axis_tlast`, out, 1: delayed `s_axis_tlast`.
- `mode`, in, 2: 0 = re, 1 = im, 2 = |re|+|im|, 3 = ramp.
- `shift`, in, 5: arithmetic right shift, 0..`CW`; values above `CW` clamp to `CW`.
- `marker_en`, in, 1: enables marker override on `tuser` beats.
- `sat_count`, out, 16: saturating count of clipped output beats.

## Operation
Stage 1 (S1), source select. Captured on an accepted input beat.
- mode 0: sign-extend `re` to `CW`+2 bits.
- mode 1: sign-extend `im` to `CW`+2 bits.
- mode 2: |re|+|im|, unsigned, `CW`+1 bits, zero-extended to `CW`+2. |−2^(CW−1)| = 2^(CW−1) exactly, no wrap.
- mode 3: ramp counter. A `DAC_WIDTH`-bit signed register that increments by 1 per accepted beat and wraps from +max to −min. It is reset to 0 by an accepted `tuser` beat, which itself outputs 0.
- `mode`, `shift` and `marker_en` are sampled on the accepted beat; they are never applied retroactively.
- The marker flag, `tuser & marker_en`, travels with the beat.

Stage 2 (S2), scale and saturate.
- Arithmetic right shift of the `CW`+2-bit value by `shift`.
- Clip to [−2^(DAC_WIDTH−1), 2^(DAC_WIDTH−1)−1]. A clipped beat sets the clip flag.
- A marker beat outputs `MARKER_VALUE` and never sets the clip flag.
- All lanes carry the same value, sign-extended to `LANE_WIDTH`.

`sat_count` behaviour:
- Increments by 1 when a beat with the clip flag is accepted on the output (`m_axis_tvalid & m_axis_tready`).
- Sticks at 0xFFFF.
- Clears only on reset.

## Timing
- Latency: an input accepted at cycle n appears on `m_axis_tvalid` at n+2 when there is no backpressure. Throughput is 1 beat/cycle.
- `s_axis_tready` = !v1 | !v2 | `m_axis_tready`, where v1 = S1 valid and v2 = `m_axis_tvalid`.
- S2 loads from S1 when !v2 or `m_axis_tready`. S1 loads when `s_axis_tready`.
- Combinational path exists from `m_axis_tready` to `s_axis_tready`; there are no other combinational input-to-output paths.
- Under a stall, `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid` hold stable until accepted. At most 2 beats are buffered, and no beat is dropped or duplicated.
- Reset, including mid-frame: v1 = v2 = 0, `m_axis_tdata` = 0, `m_axis_tlast` = 0, `sat_count` = 0, ramp = 0.
  - `s_axis_tready` is 1 while `aresetn` is high and the pipeline is empty.
  - `s_axis_tready` is 0 while `aresetn` is low.
- `tuser` and `tlast` on the same beat: marker override applies and `tlast` propagates.

## Structure
- Package `fft_dac_pkg` holds:
  - the mode encoding constants;
  - `SHIFT_W` = 5;
  - the saturation bounds as functions of `DAC_WIDTH`.
- Sub-module `fft_dac_scale_sat`: shift, clip and clip-flag logic, purely combinational. It is instantiated once inside S2.
- The top level holds the handshake control, the ramp register, the S1/S2 registers, lane packing and `sat_count`.

## Test plan
All scenarios use default parameters.
- mode 0, `shift`=2, re=0x1000 → lanes = 0x0400 on both, 2 cycles after acceptance, with `sat_count` unchanged.
- mode 0, `shift`=0, re=0x7FFF, then re=0x8000 → lanes 0x1FFF, then 0xE000, and `sat_count`=2.
- mode 2, `shift`=0, re=−300, im=400 → lanes 0x02BC. Same stimulus in mode 1 → 0x0190.
- `tuser`=1, `marker_en`=1, re=0x8000 → lanes 0x1FFF and `sat_count` unchanged. With `marker_en`=0 → 0xE000 and the count increments.
- Streaming 8 beats with `m_axis_tready` low for cycles 3–7 → `s_axis_tready` falls after 2 buffered beats. All 8 outputs arrive in order with data and `tlast` stable during the stall.
- mode 3 with `tuser` on beat 0, 5 beats, then `aresetn` pulsed low mid-stream:
  - outputs 0,1,2,3,4;
  - after reset, `m_axis_tvalid`=0, `m_axis_tdata`=0 and `sat_count`=0;
  - the next beat outputs ramp value 0.
